spr_result_arbiter: RTL and testbench
=====================================

// Module: spr_result_arbiter
// PURPOSE
//  Collects SPR results (XER/LR/CTR) from SOURCES execution units and serialises them onto the
//  single write port of the SPR register file (write_addr/enable/value/rs_id). Each source has a
//  small FIFO with valid/ready handshake. A round-robin arbiter picks one entry per cycle, and
//  registered outputs drive the SPR file. Sits directly downstream of the execution units.
// PARAMETERS
//  SOURCES      4   number of producing execution units (>=2)
//  RS_ID_WIDTH  5   reservation-station ID width; matches the SPR register file
//  FIFO_DEPTH   2   entries per source FIFO; power of two, >=2
// PORTS
//  clk            in   1            single clock
//  rst_n          in   1            reset; asynchronous, active-low
//  src_valid[s]   in   1            source s presents a result
//  src_ready[s]   out  1            source s FIFO can accept this cycle
//  src_addr[s]    in   10           SPR number (0:9)
//  src_value[s]   in   32           result (0:31)
//  src_rs_id[s]   in   RS_ID_WIDTH  producing reservation station
//  wb_enable      out  1            drives SPR file write_enable
//  wb_addr        out  10           drives write_addr
//  wb_value       out  32           drives write_value
//  wb_rs_id       out  RS_ID_WIDTH  drives write_rs_id
//  illegal_addr   out  1            only with SPR_ARB_ADDR_CHECK_EN; 1-cycle pulse
//  illegal_rs_id  out  RS_ID_WIDTH  only with SPR_ARB_ADDR_CHECK_EN; RS ID of dropped entry
// BEHAVIOUR
//  - Reset (rst_n=0, async): all FIFOs empty, rr_ptr=0, wb_*=0, illegal_*=0. Buffered entries are lost.
//    src_ready=1 for all sources once rst_n=1 (no pre-reset ready glitch required).
//  - Push: an entry is pushed when src_valid[s]&&src_ready[s] at posedge. src_ready[s] = (count[s]!=FIFO_DEPTH)
//    from the registered count only. A full FIFO popped in the same cycle still shows ready=0.
//  - Push and pop on one non-full FIFO in the same cycle: count unchanged; order preserved.
//  - Arbitration (comb): scan sources from rr_ptr upward, mod SOURCES; grant the first non-empty FIFO
//    and pop its head. No grant when all FIFOs are empty.
//  - rr_ptr <= grant+1 mod SOURCES on a grant; otherwise it holds.
//  - Output register: on a grant, wb_enable<=1 and wb_addr/value/rs_id<=head fields. Without a grant,
//    wb_enable<=0 and the data fields hold their last value.
//  - Latency: push at edge N -> grant in cycle N+1 -> wb_enable high in cycle N+2 (minimum 2 cycles).
//    The SPR file never backpressures, so peak throughput is 1 result per cycle.
//  - Ordering: FIFO order within a source; no ordering across sources.
//    Stale rs_id writes are filtered by the SPR file, not here.
//  - Boundary: all sources valid and every FIFO full -> each source is served once per SOURCES
//    cycles. No starvation.
// CONFIGURATION
//  SPR_ARB_ADDR_CHECK_EN defined: the granted entry's addr is checked against {1,8,9}.
//    If not a member, the entry is still popped and rr_ptr still advances. wb_enable<=0,
//    illegal_addr<=1 for one cycle, and illegal_rs_id<=entry rs_id.
//  Not defined: illegal_* ports do not exist. Every granted entry is forwarded unchanged.
// STRUCTURE
//  ppc_types package gets: spr_wb_t packed struct {addr[0:9], value[0:31], rs_id}. RS_ID_WIDTH
//    is passed as a parameter, so the struct is a parameterised typedef inside the module if the
//    package cannot hold it. Constants SPR_XER=1, SPR_LR=8, SPR_CTR=9 also go in ppc_types.
//  Sub-module spr_wb_fifo: synchronous FIFO of spr_wb_t with push, pop, full, empty and count.
//    It is instantiated SOURCES times via generate. Arbiter and output register stay in the top.
// TESTING
//  1 Reset: rst_n low mid-traffic with 2 entries queued -> wb_enable=0 immediately. After release,
//    no stale writes; src_ready all 1.
//  2 Latency: src0 pushes {addr=8,value=32'hDEAD_BEEF,rs_id=3} at edge N -> wb_enable=1 in cycle N+2
//    only, with addr=8, value=DEADBEEF, rs_id=3.
//  3 Round robin: all 4 sources push one entry in the same cycle, rr_ptr=0 ->
//    writes in source order 0,1,2,3 on consecutive cycles; rr_ptr ends at 0.
//  4 Full/backpressure: FIFO_DEPTH=2; src1 holds valid for 5 cycles while src0 is busy ->
//    src_ready[1] drops after 2 accepted. All accepted values appear in order; none are lost or duplicated.
//  5 Fairness: sources 0 and 2 continuously valid -> grants alternate 0,2,0,2. Neither waits more than 1 cycle.
//  6 Addr check (EN defined): push addr=5, rs_id=7 -> illegal_addr pulses with rs_id 7 and wb_enable stays 0.
//    The next queued entry is written in the following cycle.

Source files
------------

// File: rtl/ppc_types_pkg.sv
// Shared PowerPC SPR types and constants for the SPR writeback path.
package ppc_types;

  localparam int SPR_ADDR_W = 10;
  localparam int SPR_VAL_W  = 32;

  localparam logic [0:SPR_ADDR_W-1] SPR_XER = 10'd1;
  localparam logic [0:SPR_ADDR_W-1] SPR_LR  = 10'd8;
  localparam logic [0:SPR_ADDR_W-1] SPR_CTR = 10'd9;

  // Only XER, LR and CTR are produced by the execution units feeding this path.
  function automatic logic spr_is_legal(input logic [0:SPR_ADDR_W-1] a);
    return (a == SPR_XER) || (a == SPR_LR) || (a == SPR_CTR);
  endfunction

endpackage

// File: rtl/spr_result_arbiter_wb_fifo.sv
// spr_wb_fifo: small synchronous FIFO holding SPR writeback entries for one source.
// DEPTH must be a power of two so the pointers wrap naturally.
module spr_wb_fifo #(
  parameter type T     = logic [46:0],
  parameter int  DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  T              i_data,
  input  logic          i_pop,
  output T              o_head,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  T              r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  assign o_head  = r_mem[r_rd];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  // Pointer and occupancy tracking; push+pop together leaves the count unchanged.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Entry storage; contents are don't-care while the slot is empty, so no reset.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

endmodule

// File: rtl/spr_result_arbiter.sv
// spr_result_arbiter: per-source FIFOs, round-robin pick, registered SPR file write port.
// Optional feature macro SPR_ARB_ADDR_CHECK_EN: drop entries whose SPR is not XER/LR/CTR
// and flag them on o_illegal_addr / o_illegal_rs_id.
module spr_result_arbiter
  import ppc_types::*;
#(
  parameter int  SOURCES     = 4,
  parameter int  RS_ID_WIDTH = 5,
  parameter int  FIFO_DEPTH  = 2,
  localparam int PTR_W       = $clog2(SOURCES),
  localparam int CNT_W       = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst_n,
  input  logic [SOURCES-1:0]                     i_src_valid,
  output logic [SOURCES-1:0]                     o_src_ready,
  input  logic [SOURCES-1:0][0:SPR_ADDR_W-1]     i_src_addr,
  input  logic [SOURCES-1:0][0:SPR_VAL_W-1]      i_src_value,
  input  logic [SOURCES-1:0][RS_ID_WIDTH-1:0]    i_src_rs_id,
  output logic                                   o_wb_enable,
  output logic [0:SPR_ADDR_W-1]                  o_wb_addr,
  output logic [0:SPR_VAL_W-1]                   o_wb_value,
  output logic [RS_ID_WIDTH-1:0]                 o_wb_rs_id
`ifdef SPR_ARB_ADDR_CHECK_EN
 ,output logic                                   o_illegal_addr,
  output logic [RS_ID_WIDTH-1:0]                 o_illegal_rs_id
`endif
);

  typedef struct packed {
    logic [0:SPR_ADDR_W-1]  addr;
    logic [0:SPR_VAL_W-1]   value;
    logic [RS_ID_WIDTH-1:0] rs_id;
  } spr_wb_t;

  spr_wb_t                 w_head [SOURCES];
  logic [SOURCES-1:0]      w_full;
  logic [SOURCES-1:0]      w_empty;
  logic [SOURCES-1:0]      w_pop;
  logic [CNT_W-1:0]        w_cnt [SOURCES];
  logic                    w_grant;
  logic [PTR_W-1:0]        w_gidx;
  logic [PTR_W-1:0]        w_rr_nxt;
  spr_wb_t                 w_sel;
  logic [PTR_W-1:0]        r_rr_ptr;
  logic                    r_wb_en;
  spr_wb_t                 r_wb;

  for (genvar s = 0; s < SOURCES; s++) begin : g_src
    // Ready comes from the registered count only; a pop this cycle does not reopen a full FIFO.
    assign o_src_ready[s] = (w_cnt[s] != CNT_W'(FIFO_DEPTH));
    assign w_pop[s]       = w_grant && (w_gidx == PTR_W'(s));

    spr_wb_fifo #(.T(spr_wb_t), .DEPTH(FIFO_DEPTH)) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (i_src_valid[s] & ~w_full[s]),
      .i_data  ({i_src_addr[s], i_src_value[s], i_src_rs_id[s]}),
      .i_pop   (w_pop[s]),
      .o_head  (w_head[s]),
      .o_full  (w_full[s]),
      .o_empty (w_empty[s]),
      .o_count (w_cnt[s])
    );
  end

  // Round-robin scan starting at r_rr_ptr; first non-empty FIFO wins.
  always_comb begin
    int k;
    k       = 0;
    w_grant = 1'b0;
    w_gidx  = '0;
    for (int i = 0; i < SOURCES; i++) begin
      k = int'(r_rr_ptr) + i;
      if (k >= SOURCES) k = k - SOURCES;
      if (!w_grant && !w_empty[PTR_W'(k)]) begin
        w_grant = 1'b1;
        w_gidx  = PTR_W'(k);
      end
    end
  end

  assign w_sel    = w_head[w_gidx];
  assign w_rr_nxt = (w_gidx == PTR_W'(SOURCES - 1)) ? '0 : w_gidx + 1'b1;

  // Pointer moves past the winner so it becomes lowest priority next cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     r_rr_ptr <= '0;
    else if (w_grant) r_rr_ptr <= w_rr_nxt;
  end

`ifdef SPR_ARB_ADDR_CHECK_EN
  logic                   r_ill;
  logic [RS_ID_WIDTH-1:0] r_ill_rs;

  // Write port register; unknown SPRs are consumed but suppressed and reported.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wb_en  <= 1'b0;
      r_wb     <= '0;
      r_ill    <= 1'b0;
      r_ill_rs <= '0;
    end else begin
      r_ill <= 1'b0;
      if (w_grant && !spr_is_legal(w_sel.addr)) begin
        r_wb_en  <= 1'b0;
        r_ill    <= 1'b1;
        r_ill_rs <= w_sel.rs_id;
      end else begin
        r_wb_en <= w_grant;
        if (w_grant) r_wb <= w_sel;
      end
    end
  end

  assign o_illegal_addr  = r_ill;
  assign o_illegal_rs_id = r_ill_rs;
`else
  // Write port register; data fields hold when nothing is granted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wb_en <= 1'b0;
      r_wb    <= '0;
    end else begin
      r_wb_en <= w_grant;
      if (w_grant) r_wb <= w_sel;
    end
  end
`endif

  assign o_wb_enable = r_wb_en;
  assign o_wb_addr   = r_wb.addr;
  assign o_wb_value  = r_wb.value;
  assign o_wb_rs_id  = r_wb.rs_id;

endmodule

// File: tb/tb_spr_result_arbiter.sv
// Directed bench for spr_result_arbiter: reset, latency, round robin, backpressure, fairness,
// and the optional SPR address check when SPR_ARB_ADDR_CHECK_EN is defined.
module tb_spr_result_arbiter;

  localparam int S  = 4;
  localparam int RW = 5;

  logic                   gclk = 1'b0;
  logic                   rst_n;
  logic [S-1:0]           valid;
  logic [S-1:0]           ready;
  logic [S-1:0][0:9]      addr;
  logic [S-1:0][0:31]     value;
  logic [S-1:0][RW-1:0]   rsid;
  logic                   wb_en;
  logic [0:9]             wb_addr;
  logic [0:31]            wb_value;
  logic [RW-1:0]          wb_rs;
`ifdef SPR_ARB_ADDR_CHECK_EN
  logic                   ill;
  logic [RW-1:0]          ill_rs;
`endif

  int checks = 0;
  int errors = 0;

  always #5 gclk = ~gclk;

  spr_result_arbiter #(.SOURCES(S), .RS_ID_WIDTH(RW), .FIFO_DEPTH(2)) dut (
    .i_clk           (gclk),
    .i_rst_n         (rst_n),
    .i_src_valid     (valid),
    .o_src_ready     (ready),
    .i_src_addr      (addr),
    .i_src_value     (value),
    .i_src_rs_id     (rsid),
    .o_wb_enable     (wb_en),
    .o_wb_addr       (wb_addr),
    .o_wb_value      (wb_value),
    .o_wb_rs_id      (wb_rs)
`ifdef SPR_ARB_ADDR_CHECK_EN
   ,.o_illegal_addr  (ill),
    .o_illegal_rs_id (ill_rs)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, want);
    end
  endtask

  task automatic chk_wb(input string tag, input logic [31:0] v, input logic [9:0] a,
                        input logic [RW-1:0] r);
    chk({tag, "_en"}, 64'(wb_en), 64'd1);
    chk({tag, "_val"}, 64'(wb_value), 64'(v));
    chk({tag, "_addr"}, 64'(wb_addr), 64'(a));
    chk({tag, "_rs"}, 64'(wb_rs), 64'(r));
  endtask

  task automatic step();
    @(posedge gclk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    valid = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  logic [31:0]   t4_v0 [5] = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003, 32'hA000_0003};
  logic [31:0]   t4_v1 [5] = '{32'hB000_0000, 32'hB000_0001, 32'hB000_0002, 32'hB000_0002, 32'hB000_0003};
  logic [1:0]    t4_rdy[5] = '{2'b11, 2'b11, 2'b01, 2'b10, 2'b01};
  logic [31:0]   t4_wb [9] = '{32'h0, 32'hA000_0000, 32'hB000_0000, 32'hA000_0001, 32'hB000_0001,
                               32'hA000_0002, 32'hB000_0002, 32'hA000_0003, 32'h0};
  logic [RW-1:0] t4_rs [9] = '{5'd0, 5'd0, 5'd1, 5'd0, 5'd1, 5'd0, 5'd1, 5'd0, 5'd0};

  initial begin
    rst_n = 1'b0;
    valid = '0;
    addr  = '0;
    value = '0;
    rsid  = '0;

    // ---- reset state, then async reset with entries queued
    #1;
    chk("rst_en", 64'(wb_en), 64'd0);
    chk("rst_data", 64'(wb_value), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    chk("rst_ready", 64'(ready), 64'hF);
    for (int s = 0; s < 3; s++) begin
      valid[s] = 1'b1;
      addr[s]  = 10'd8;
      value[s] = 32'h1000 + 32'(s);
      rsid[s]  = RW'(s);
    end
    step();
    valid = '0;
    chk("mid_en0", 64'(wb_en), 64'd0);
    step();
    chk_wb("mid_w0", 32'h1000, 10'd8, 5'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_en", 64'(wb_en), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    chk("post_rst_ready", 64'(ready), 64'hF);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("no_stale", 64'(wb_en), 64'd0);
    end

    // ---- latency: push at edge N, write visible after edge N+1 only
    do_reset();
    valid[0] = 1'b1; addr[0] = 10'd8; value[0] = 32'hDEAD_BEEF; rsid[0] = 5'd3;
    step();
    valid = '0;
    chk("lat_n1", 64'(wb_en), 64'd0);
    step();
    chk_wb("lat_n2", 32'hDEAD_BEEF, 10'd8, 5'd3);
    step();
    chk("lat_n3", 64'(wb_en), 64'd0);
    chk("lat_hold", 64'(wb_value), 64'hDEAD_BEEF);

    // ---- round robin: four simultaneous pushes drain 0,1,2,3
    do_reset();
    for (int s = 0; s < S; s++) begin
      valid[s] = 1'b1;
      addr[s]  = (s == 1) ? 10'd8 : (s == 2) ? 10'd9 : 10'd1;
      value[s] = 32'h100 + 32'(s);
      rsid[s]  = RW'(10 + s);
    end
    step();
    valid = '0;
    chk("rr_idle", 64'(wb_en), 64'd0);
    step(); chk_wb("rr_s0", 32'h100, 10'd1, 5'd10);
    step(); chk_wb("rr_s1", 32'h101, 10'd8, 5'd11);
    step(); chk_wb("rr_s2", 32'h102, 10'd9, 5'd12);
    step(); chk_wb("rr_s3", 32'h103, 10'd1, 5'd13);
    step(); chk("rr_done", 64'(wb_en), 64'd0);
    // pointer back at 0: src0 must beat src3
    valid[0] = 1'b1; value[0] = 32'h200; rsid[0] = 5'd0; addr[0] = 10'd9;
    valid[3] = 1'b1; value[3] = 32'h203; rsid[3] = 5'd3; addr[3] = 10'd9;
    step();
    valid = '0;
    step(); chk_wb("rr_wrap0", 32'h200, 10'd9, 5'd0);
    step(); chk_wb("rr_wrap3", 32'h203, 10'd9, 5'd3);

    // ---- backpressure: src0 and src1 held valid five cycles, depth 2
    do_reset();
    addr[0] = 10'd8; rsid[0] = 5'd0;
    addr[1] = 10'd8; rsid[1] = 5'd1;
    for (int k = 0; k < 9; k++) begin
      if (k < 5) begin
        valid[1:0] = 2'b11;
        value[0]   = t4_v0[k];
        value[1]   = t4_v1[k];
        chk($sformatf("bp_ready%0d", k), 64'(ready[1:0]), 64'(t4_rdy[k]));
      end else begin
        valid = '0;
      end
      step();
      if (k == 0 || k == 8) begin
        chk($sformatf("bp_en%0d", k), 64'(wb_en), 64'd0);
      end else begin
        chk_wb($sformatf("bp_w%0d", k), t4_wb[k], 10'd8, t4_rs[k]);
      end
    end

    // ---- fairness: src0 and src2 always valid alternate every cycle
    do_reset();
    valid[0] = 1'b1; addr[0] = 10'd1; value[0] = 32'h5000; rsid[0] = 5'd0;
    valid[2] = 1'b1; addr[2] = 10'd1; value[2] = 32'h5002; rsid[2] = 5'd2;
    step();
    chk("fair_first", 64'(wb_en), 64'd0);
    for (int k = 2; k < 10; k++) begin
      step();
      chk($sformatf("fair_en%0d", k), 64'(wb_en), 64'd1);
      chk($sformatf("fair_rs%0d", k), 64'(wb_rs), (k % 2 == 0) ? 64'd0 : 64'd2);
    end
    valid = '0;

`ifdef SPR_ARB_ADDR_CHECK_EN
    // ---- address check: SPR 5 is dropped and reported, next entry follows
    do_reset();
    valid[0] = 1'b1; addr[0] = 10'd5; value[0] = 32'h55; rsid[0] = 5'd7;
    valid[1] = 1'b1; addr[1] = 10'd9; value[1] = 32'h99; rsid[1] = 5'd4;
    step();
    valid = '0;
    chk("ill_idle", 64'(ill), 64'd0);
    step();
    chk("ill_en", 64'(wb_en), 64'd0);
    chk("ill_pulse", 64'(ill), 64'd1);
    chk("ill_rs", 64'(ill_rs), 64'd7);
    step();
    chk_wb("ill_next", 32'h99, 10'd9, 5'd4);
    chk("ill_clear", 64'(ill), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
